// File: rtl/filterbank_scheduler_if.sv
// Handshake/bus bundle for filterbank_scheduler.
//   valid_in / carrier_sample_in / mod_sample_in : per-frame sample pair from the front end
//   mac_start_out / mac_chan_out / mac_src_out / mac_sample_out / mac_done_in :
//       job launch and completion handshake with the shared biquad/MAC engine
//   busy_out / valid_out / overrun_out / timeout_out : frame status toward the mixer
// The slave modport is the scheduler's view, the master modport is the view of
// whatever feeds samples, plays the engine and consumes the status.
interface filterbank_scheduler_if #(
  parameter int NUM_CHANNELS  = 8,
  parameter int CARRIER_WIDTH = 16,
  parameter int MOD_WIDTH     = 24
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                            valid_in;
  logic signed [CARRIER_WIDTH-1:0] carrier_sample_in;
  logic signed [MOD_WIDTH-1:0]     mod_sample_in;
  logic                            mac_start_out;
  logic [CW-1:0]                   mac_chan_out;
  logic                            mac_src_out;
  logic signed [MOD_WIDTH-1:0]     mac_sample_out;
  logic                            mac_done_in;
  logic                            busy_out;
  logic                            valid_out;
  logic                            overrun_out;
  logic                            timeout_out;

  modport slave (
    input  valid_in, carrier_sample_in, mod_sample_in, mac_done_in,
    output mac_start_out, mac_chan_out, mac_src_out, mac_sample_out,
           busy_out, valid_out, overrun_out, timeout_out
  );

  modport master (
    output valid_in, carrier_sample_in, mod_sample_in, mac_done_in,
    input  mac_start_out, mac_chan_out, mac_src_out, mac_sample_out,
           busy_out, valid_out, overrun_out, timeout_out
  );
endinterface

// File: rtl/filterbank_scheduler.sv
// filterbank_scheduler
// Time-multiplexes one shared biquad/MAC engine over the 2*NUM_CHANNELS jobs of
// an audio frame (carrier then modulator job for each channel, channel 0 first).
// A sample pair is latched when valid_in arrives in IDLE; jobs are launched one
// at a time with a 1-cycle mac_start_out and retired by mac_done_in. valid_out
// pulses once every job of the frame has completed.
// Ports:
//   clk_in  : system clock
//   rst_in  : synchronous active-high reset, aborts any frame in progress
//   bus     : filterbank_scheduler_if.slave
//     valid_in, carrier_sample_in, mod_sample_in -> sample pair strobe
//     mac_start_out, mac_chan_out, mac_src_out, mac_sample_out <- job launch
//     mac_done_in                                 -> job completion
//     busy_out, valid_out                         <- frame status
//     overrun_out, timeout_out                    <- sticky error flags
// All outputs are registered.
module filterbank_scheduler #(
  parameter int NUM_CHANNELS   = 8,
  parameter int CARRIER_WIDTH  = 16,
  parameter int MOD_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clk_in,
  input logic                   rst_in,
  filterbank_scheduler_if.slave bus
);

  localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int NJOBS = 2 * NUM_CHANNELS;
  localparam int JW    = $clog2(NJOBS);
  localparam int TW    = $clog2(TIMEOUT_CYCLES);

  localparam logic [JW-1:0] LAST_JOB   = JW'(NJOBS - 1);
  // The wait counter reads 0 in the first WAIT cycle, so the engine is given up
  // on when the count reaches TIMEOUT_CYCLES-2: timeout_out then rises exactly
  // TIMEOUT_CYCLES cycles after the job's start pulse.
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                          r_state, w_state_next;
  logic [JW-1:0]                   r_job, w_job_next;
  logic [TW-1:0]                   r_wait, w_wait_next;
  logic signed [CARRIER_WIDTH-1:0] r_carrier, w_carrier_next;
  logic signed [MOD_WIDTH-1:0]     r_mod, w_mod_next;
  logic                            w_timeout_hit;

  logic                            w_src_next;
  logic [CW-1:0]                   w_chan_next;
  logic signed [MOD_WIDTH-1:0]     w_sample_next;

  logic                            r_start, r_src, r_busy, r_valid, r_overrun, r_timeout;
  logic [CW-1:0]                   r_chan;
  logic signed [MOD_WIDTH-1:0]     r_sample;

  function automatic logic signed [MOD_WIDTH-1:0] sext_carrier(
    input logic signed [CARRIER_WIDTH-1:0] s
  );
    return MOD_WIDTH'(s);
  endfunction

  always_comb begin
    w_state_next   = r_state;
    w_job_next     = r_job;
    w_wait_next    = r_wait;
    w_carrier_next = r_carrier;
    w_mod_next     = r_mod;
    w_timeout_hit  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.valid_in) begin
          w_carrier_next = bus.carrier_sample_in;
          w_mod_next     = bus.mod_sample_in;
          w_job_next     = '0;
          w_state_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // mac_done_in is deliberately not looked at here.
        w_wait_next  = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over an expiring wait count
        if (bus.mac_done_in) begin
          if (r_job == LAST_JOB) begin
            w_state_next = S_DONE;
          end else begin
            w_job_next   = r_job + 1'b1;
            w_state_next = S_ISSUE;
          end
        end else if (r_wait == WAIT_LIMIT) begin
          w_timeout_hit = 1'b1;
          w_state_next  = S_IDLE;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Job descriptor for whatever job the next state will launch; outputs are
  // registered from the next state so the start pulse appears one cycle after
  // acceptance or done.
  always_comb begin
    w_src_next    = w_job_next[0];
    w_chan_next   = CW'(w_job_next >> 1);
    w_sample_next = w_src_next ? w_mod_next : sext_carrier(w_carrier_next);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_job     <= '0;
      r_wait    <= '0;
      r_carrier <= '0;
      r_mod     <= '0;
      r_start   <= 1'b0;
      r_chan    <= '0;
      r_src     <= 1'b0;
      r_sample  <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_job     <= w_job_next;
      r_wait    <= w_wait_next;
      r_carrier <= w_carrier_next;
      r_mod     <= w_mod_next;
      r_start   <= (w_state_next == S_ISSUE);
      r_busy    <= (w_state_next == S_ISSUE) || (w_state_next == S_WAIT);
      r_valid   <= (w_state_next == S_DONE);
      // job fields only move on a launch, so they hold through WAIT and IDLE
      if (w_state_next == S_ISSUE) begin
        r_chan   <= w_chan_next;
        r_src    <= w_src_next;
        r_sample <= w_sample_next;
      end
      // includes the DONE cycle: a pair arriving with valid_out is dropped
      if (bus.valid_in && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.mac_start_out  = r_start;
  assign bus.mac_chan_out   = r_chan;
  assign bus.mac_src_out    = r_src;
  assign bus.mac_sample_out = r_sample;
  assign bus.busy_out       = r_busy;
  assign bus.valid_out      = r_valid;
  assign bus.overrun_out    = r_overrun;
  assign bus.timeout_out    = r_timeout;

endmodule

// File: tb/tb_filterbank_scheduler.sv
// Testbench for filterbank_scheduler. A single thread advances the clock one
// cycle at a time: at each falling edge it records what the DUT shows, plays
// the MAC engine (done a chosen number of cycles after each start) and drives
// the inputs for that cycle. Expected job order, samples and timing come from
// plain arithmetic over the per-job engine latencies.
module tb_filterbank_scheduler;
  localparam int N  = 8;
  localparam int CW = 16;
  localparam int MW = 24;
  localparam int T  = 255;
  localparam int NJ = 2 * N;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  filterbank_scheduler_if #(.NUM_CHANNELS(N), .CARRIER_WIDTH(CW), .MOD_WIDTH(MW)) bus ();

  filterbank_scheduler #(
    .NUM_CHANNELS(N), .CARRIER_WIDTH(CW), .MOD_WIDTH(MW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int lat [NJ];
  int mute_job = -1;
  int frame_job = 0;
  int eng_cnt = 0;
  bit eng_pend = 1'b0;
  bit vin_req = 1'b0;
  bit spur_req = 1'b0;
  bit rst_req = 1'b1;
  int fr_car = 0;
  int fr_mod = 0;

  int st_cyc[$];
  int st_chan[$];
  int st_src[$];
  logic [MW-1:0] st_smp[$];
  int vo_cyc[$];
  int busy_first, busy_last, busy_cnt, to_first;

  // ---------------- reference model ----------------
  function automatic int exp_start(int j);
    int s = 1;
    for (int k = 0; k < j; k++) s += lat[k] + 1;
    return s;
  endfunction

  function automatic int exp_end();
    return exp_start(NJ - 1) + lat[NJ - 1] + 1;
  endfunction

  function automatic logic [MW-1:0] exp_sample(int j, int car, int md);
    longint v;
    v = (j % 2 == 1) ? longint'(md) : longint'(car);
    return v[MW-1:0];
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic tick();
    bit done_now;
    @(negedge clk_in);
    cyc++;
    done_now = 1'b0;
    if (eng_pend) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        done_now = 1'b1;
        eng_pend = 1'b0;
      end
    end
    if (bus.mac_start_out) begin
      st_cyc.push_back(cyc);
      st_chan.push_back(int'(bus.mac_chan_out));
      st_src.push_back(int'(bus.mac_src_out));
      st_smp.push_back(bus.mac_sample_out);
      if (frame_job != mute_job) begin
        eng_pend = 1'b1;
        eng_cnt  = (frame_job < NJ) ? lat[frame_job] : 1;
      end
      frame_job++;
    end
    if (bus.valid_out) vo_cyc.push_back(cyc);
    if (bus.busy_out) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
    if (bus.timeout_out && to_first < 0) to_first = cyc;
    bus.mac_done_in       = done_now | spur_req;
    bus.valid_in          = vin_req;
    bus.carrier_sample_in = CW'(fr_car);
    bus.mod_sample_in     = MW'(fr_mod);
    rst_in                = rst_req;
    vin_req  = 1'b0;
    spur_req = 1'b0;
  endtask

  task automatic clear_rec();
    st_cyc.delete(); st_chan.delete(); st_src.delete(); st_smp.delete(); vo_cyc.delete();
    frame_job = 0; eng_pend = 1'b0; eng_cnt = 0;
    busy_first = -1; busy_last = -1; busy_cnt = 0; to_first = -1;
  endtask

  task automatic set_lat(bit rnd);
    for (int k = 0; k < NJ; k++) lat[k] = rnd ? int'($urandom_range(1, 6)) : 3;
  endtask

  task automatic rand_samples();
    fr_car = int'($signed(CW'($urandom)));
    fr_mod = int'($signed(MW'($urandom)));
  endtask

  // drives valid_in for one cycle; returns the acceptance cycle
  task automatic start_frame(output int acc);
    vin_req = 1'b1;
    tick();
    acc = cyc;
  endtask

  task automatic run_until_valid(input int budget);
    int n = 0;
    while (vo_cyc.size() == 0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_req = 1'b1;
    repeat (3) tick();
    vectors++; if (bus.mac_start_out !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b expected 0", bus.mac_start_out); end
    vectors++; if (bus.mac_chan_out !== '0) begin miscompares++; $display("FAIL reset_chan: got %0d expected 0", bus.mac_chan_out); end
    vectors++; if (bus.mac_src_out !== 1'b0) begin miscompares++; $display("FAIL reset_src: got %b expected 0", bus.mac_src_out); end
    vectors++; if (bus.mac_sample_out !== '0) begin miscompares++; $display("FAIL reset_sample: got %h expected 0", bus.mac_sample_out); end
    vectors++; if (bus.busy_out !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy_out); end
    vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
    vectors++; if (bus.overrun_out !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun_out); end
    vectors++; if (bus.timeout_out !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout_out); end
    rst_req = 1'b0;
    clear_rec();
    repeat (5) tick();
    vectors++; if (busy_cnt !== 0 || st_cyc.size() !== 0 || vo_cyc.size() !== 0) begin
      miscompares++; $display("FAIL reset_idle: busy cycles %0d starts %0d valids %0d, expected all 0", busy_cnt, st_cyc.size(), vo_cyc.size());
    end
  endtask

  task automatic test_nominal();
    int acc;
    set_lat(1'b0);
    clear_rec();
    fr_car = -2;
    fr_mod = 'h012345;
    start_frame(acc);
    run_until_valid(200);
    vectors++; if (st_cyc.size() !== NJ) begin miscompares++; $display("FAIL nominal_starts: got %0d expected %0d", st_cyc.size(), NJ); end
    for (int j = 0; j < NJ && j < st_cyc.size(); j++) begin
      vectors++;
      if (st_chan[j] != j / 2 || st_src[j] != j % 2 || st_smp[j] !== exp_sample(j, fr_car, fr_mod) || st_cyc[j] - acc != exp_start(j)) begin
        miscompares++;
        $display("FAIL nominal_job%0d: got ch%0d src%0d smp %h cyc %0d expected ch%0d src%0d smp %h cyc %0d",
                 j, st_chan[j], st_src[j], st_smp[j], st_cyc[j] - acc, j / 2, j % 2, exp_sample(j, fr_car, fr_mod), exp_start(j));
      end
    end
    vectors++; if (vo_cyc.size() !== 1 || vo_cyc[0] - acc != 65) begin
      miscompares++; $display("FAIL nominal_valid: got count %0d cycle %0d expected count 1 cycle 65", vo_cyc.size(), (vo_cyc.size() > 0) ? vo_cyc[0] - acc : -1);
    end
    vectors++; if (busy_first - acc != 1 || busy_last - acc != 64 || busy_cnt != 64) begin
      miscompares++; $display("FAIL nominal_busy: got first %0d last %0d count %0d expected 1 64 64", busy_first - acc, busy_last - acc, busy_cnt);
    end
    vectors++; if (bus.overrun_out !== 1'b0 || bus.timeout_out !== 1'b0) begin
      miscompares++; $display("FAIL nominal_flags: got overrun %b timeout %b expected 0 0", bus.overrun_out, bus.timeout_out);
    end
  endtask

  // frames started the cycle after the previous valid_out, random data and latency
  task automatic test_back_to_back();
    int acc;
    for (int f = 0; f < 6; f++) begin
      set_lat(1'b1);
      rand_samples();
      clear_rec();
      start_frame(acc);
      run_until_valid(400);
      vectors++; if (st_cyc.size() !== NJ) begin miscompares++; $display("FAIL b2b%0d_starts: got %0d expected %0d", f, st_cyc.size(), NJ); end
      for (int j = 0; j < NJ && j < st_cyc.size(); j++) begin
        vectors++;
        if (st_chan[j] != j / 2 || st_src[j] != j % 2 || st_smp[j] !== exp_sample(j, fr_car, fr_mod) || st_cyc[j] - acc != exp_start(j)) begin
          miscompares++;
          $display("FAIL b2b%0d_job%0d: got ch%0d src%0d smp %h cyc %0d expected ch%0d src%0d smp %h cyc %0d",
                   f, j, st_chan[j], st_src[j], st_smp[j], st_cyc[j] - acc, j / 2, j % 2, exp_sample(j, fr_car, fr_mod), exp_start(j));
        end
      end
      vectors++; if (vo_cyc.size() !== 1 || vo_cyc[0] - acc != exp_end()) begin
        miscompares++; $display("FAIL b2b%0d_valid: got count %0d cycle %0d expected count 1 cycle %0d", f, vo_cyc.size(), (vo_cyc.size() > 0) ? vo_cyc[0] - acc : -1, exp_end());
      end
    end
    vectors++; if (bus.overrun_out !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %b expected 0", bus.overrun_out); end
  endtask

  task automatic test_spurious_done();
    int acc;
    set_lat(1'b0);
    rand_samples();
    tick();
    spur_req = 1'b1;  // done while IDLE
    tick();
    clear_rec();
    start_frame(acc);
    spur_req = 1'b1;  // done during the first ISSUE cycle
    tick();
    while (cyc < acc + 20) tick();
    spur_req = 1'b1;  // done during the ISSUE cycle of job 5
    tick();
    run_until_valid(200);
    spur_req = 1'b1;  // done in the cycle after DONE (IDLE)
    tick();
    repeat (10) tick();
    vectors++; if (st_cyc.size() !== NJ) begin miscompares++; $display("FAIL spur_starts: got %0d expected %0d", st_cyc.size(), NJ); end
    for (int j = 0; j < NJ && j < st_cyc.size(); j++) begin
      vectors++;
      if (st_chan[j] != j / 2 || st_src[j] != j % 2 || st_cyc[j] - acc != exp_start(j)) begin
        miscompares++;
        $display("FAIL spur_job%0d: got ch%0d src%0d cyc %0d expected ch%0d src%0d cyc %0d", j, st_chan[j], st_src[j], st_cyc[j] - acc, j / 2, j % 2, exp_start(j));
      end
    end
    vectors++; if (vo_cyc.size() !== 1 || vo_cyc[0] - acc != 65) begin
      miscompares++; $display("FAIL spur_valid: got count %0d cycle %0d expected count 1 cycle 65", vo_cyc.size(), (vo_cyc.size() > 0) ? vo_cyc[0] - acc : -1);
    end
  endtask

  task automatic test_overrun();
    int acc, keep_car, keep_mod;
    set_lat(1'b0);
    rand_samples();
    keep_car = fr_car;
    keep_mod = fr_mod;
    clear_rec();
    start_frame(acc);
    while (cyc < acc + 9) tick();
    rand_samples();
    vin_req = 1'b1;
    tick();  // cycle 10
    vectors++; if (bus.overrun_out !== 1'b0) begin miscompares++; $display("FAIL overrun_before: got %b expected 0", bus.overrun_out); end
    tick();  // cycle 11
    vectors++; if (bus.overrun_out !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b expected 1", bus.overrun_out); end
    while (cyc < acc + 64) tick();
    rand_samples();
    vin_req = 1'b1;
    tick();  // cycle 65, same cycle as valid_out
    repeat (20) tick();
    vectors++; if (st_cyc.size() !== NJ) begin miscompares++; $display("FAIL overrun_starts: got %0d expected %0d", st_cyc.size(), NJ); end
    for (int j = 0; j < NJ && j < st_cyc.size(); j++) begin
      vectors++;
      if (st_smp[j] !== exp_sample(j, keep_car, keep_mod) || st_cyc[j] - acc != exp_start(j)) begin
        miscompares++;
        $display("FAIL overrun_job%0d: got smp %h cyc %0d expected smp %h cyc %0d", j, st_smp[j], st_cyc[j] - acc, exp_sample(j, keep_car, keep_mod), exp_start(j));
      end
    end
    vectors++; if (vo_cyc.size() !== 1 || vo_cyc[0] - acc != 65) begin
      miscompares++; $display("FAIL overrun_valid: got count %0d cycle %0d expected count 1 cycle 65", vo_cyc.size(), (vo_cyc.size() > 0) ? vo_cyc[0] - acc : -1);
    end
    vectors++; if (bus.overrun_out !== 1'b1 || bus.busy_out !== 1'b0) begin
      miscompares++; $display("FAIL overrun_end: got overrun %b busy %b expected 1 0", bus.overrun_out, bus.busy_out);
    end
  endtask

  task automatic test_timeout();
    int acc, t_exp;
    set_lat(1'b0);
    rand_samples();
    clear_rec();
    mute_job = 2;
    start_frame(acc);
    t_exp = exp_start(2) + T;
    while (cyc < acc + t_exp + 30) tick();
    vectors++; if (to_first - acc != t_exp) begin miscompares++; $display("FAIL timeout_cycle: got %0d expected %0d", to_first - acc, t_exp); end
    vectors++; if (st_cyc.size() !== 3 || vo_cyc.size() !== 0) begin
      miscompares++; $display("FAIL timeout_abort: got starts %0d valids %0d expected 3 0", st_cyc.size(), vo_cyc.size());
    end
    vectors++; if (busy_last - acc != t_exp - 1 || bus.busy_out !== 1'b0) begin
      miscompares++; $display("FAIL timeout_busy: got last %0d now %b expected %0d 0", busy_last - acc, bus.busy_out, t_exp - 1);
    end
    mute_job = -1;
    set_lat(1'b1);
    rand_samples();
    clear_rec();
    start_frame(acc);
    run_until_valid(400);
    vectors++; if (st_cyc.size() !== NJ || vo_cyc.size() !== 1 || vo_cyc[0] - acc != exp_end()) begin
      miscompares++; $display("FAIL timeout_recover: got starts %0d valids %0d cycle %0d expected %0d 1 %0d", st_cyc.size(), vo_cyc.size(), (vo_cyc.size() > 0) ? vo_cyc[0] - acc : -1, NJ, exp_end());
    end
    vectors++; if (bus.timeout_out !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b expected 1", bus.timeout_out); end
  endtask

  task automatic test_mid_reset();
    int acc;
    set_lat(1'b0);
    rand_samples();
    clear_rec();
    start_frame(acc);
    while (cyc < acc + exp_start(7)) tick();
    rst_req = 1'b1;
    tick();  // reset driven during a WAIT cycle of job 7
    rst_req = 1'b0;
    tick();
    vectors++;
    if (bus.mac_start_out !== 1'b0 || bus.mac_chan_out !== '0 || bus.mac_src_out !== 1'b0 || bus.mac_sample_out !== '0 ||
        bus.busy_out !== 1'b0 || bus.valid_out !== 1'b0 || bus.overrun_out !== 1'b0 || bus.timeout_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got start %b chan %0d src %b smp %h busy %b valid %b ovr %b to %b expected all 0",
               bus.mac_start_out, bus.mac_chan_out, bus.mac_src_out, bus.mac_sample_out, bus.busy_out, bus.valid_out, bus.overrun_out, bus.timeout_out);
    end
    repeat (100) tick();
    vectors++; if (st_cyc.size() !== 8 || vo_cyc.size() !== 0) begin
      miscompares++; $display("FAIL midreset_abort: got starts %0d valids %0d expected 8 0", st_cyc.size(), vo_cyc.size());
    end
    set_lat(1'b1);
    rand_samples();
    clear_rec();
    start_frame(acc);
    run_until_valid(400);
    vectors++; if (st_cyc.size() !== NJ || vo_cyc.size() !== 1 || vo_cyc[0] - acc != exp_end()) begin
      miscompares++; $display("FAIL midreset_recover: got starts %0d valids %0d cycle %0d expected %0d 1 %0d", st_cyc.size(), vo_cyc.size(), (vo_cyc.size() > 0) ? vo_cyc[0] - acc : -1, NJ, exp_end());
    end
  endtask

  initial begin
    rst_in                = 1'b1;
    bus.valid_in          = 1'b0;
    bus.carrier_sample_in = '0;
    bus.mod_sample_in     = '0;
    bus.mac_done_in       = 1'b0;
    clear_rec();
    test_reset();
    test_nominal();
    test_back_to_back();
    test_spurious_done();
    test_overrun();
    test_timeout();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, expected the run to end earlier", $time);
    $fatal(1);
  end
endmodule
